// File: rtl/counter_thr_mon.sv
// Threshold monitor for the counter stage: level irq with ack/re-arm FSM and a saturating
// overflow-event tally. Define CNT_THR_MON_HYST_EN to add re-arm hysteresis of HYST_P counts.
module counter_thr_mon #(
  parameter int unsigned WIDTH_P     = 4,
  parameter int unsigned OVF_CNT_W_P = 8,
  parameter int unsigned HYST_P      = 1
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [WIDTH_P-1:0]     cnt_val,
  input  logic                   cnt_overflow,
  input  logic                   cnt_non_zero,
  input  logic [WIDTH_P-1:0]     thr,
  input  logic                   arm,
  input  logic                   irq_ack,
  output logic                   irq,
  output logic                   ovf_seen,
  output logic [OVF_CNT_W_P-1:0] ovf_count,
  output logic [1:0]             state
);

  localparam logic [1:0] StIdle  = 2'b00;
  localparam logic [1:0] StArmed = 2'b01;
  localparam logic [1:0] StFired = 2'b10;
  localparam logic [1:0] StRearm = 2'b11;

  logic [1:0]             state_q, state_d;
  logic                   irq_q, irq_d;
  logic                   ovf_seen_q, ovf_seen_d;
  logic                   ovf_prev_q;
  logic [OVF_CNT_W_P-1:0] ovf_count_q, ovf_count_d;

  logic hit;
  logic ovf_rise;
  logic rearm_ok;

  // thr==0 would always hit on a plain compare, so fall back to the non-zero flag
  assign hit      = (thr == '0) ? cnt_non_zero : (cnt_val >= thr);
  assign ovf_rise = cnt_overflow & ~ovf_prev_q;

`ifdef CNT_THR_MON_HYST_EN
  localparam logic [WIDTH_P:0] HystW = (WIDTH_P + 1)'(HYST_P);
  // One extra bit so cnt_val + HYST_P cannot wrap back below thr
  assign rearm_ok = (({1'b0, cnt_val} + HystW) < {1'b0, thr});
`else
  assign rearm_ok = ~hit;
`endif

  always_comb begin
    state_d    = state_q;
    irq_d      = irq_q;
    ovf_seen_d = ovf_seen_q;
    if (!arm) begin
      state_d    = StIdle;
      irq_d      = 1'b0;
      ovf_seen_d = 1'b0;
    end else begin
      unique case (state_q)
        StIdle: state_d = StArmed;
        StArmed: begin
          if (hit || ovf_rise) begin
            state_d    = StFired;
            irq_d      = 1'b1;
            ovf_seen_d = ovf_rise;
          end
        end
        StFired: begin
          if (irq_ack) begin
            state_d    = StRearm;
            irq_d      = 1'b0;
            ovf_seen_d = 1'b0;
          end
        end
        StRearm: begin
          if (rearm_ok) begin
            state_d = StArmed;
          end
        end
        default: state_d = StIdle;
      endcase
    end
  end

  always_comb begin
    ovf_count_d = ovf_count_q;
    if (ovf_rise && (ovf_count_q != '1)) begin
      ovf_count_d = ovf_count_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= StIdle;
      irq_q       <= 1'b0;
      ovf_seen_q  <= 1'b0;
      ovf_prev_q  <= 1'b0;
      ovf_count_q <= '0;
    end else begin
      state_q     <= state_d;
      irq_q       <= irq_d;
      ovf_seen_q  <= ovf_seen_d;
      ovf_prev_q  <= cnt_overflow;
      ovf_count_q <= ovf_count_d;
    end
  end

  assign irq       = irq_q;
  assign ovf_seen  = ovf_seen_q;
  assign ovf_count = ovf_count_q;
  assign state     = state_q;

endmodule
